// File: rtl/fp_mult_pkg.sv
// Shared FP32 multiplier constants and result-entry layout, used by the
// multiplier and by its downstream result buffer.
package fp_mult_pkg;

  localparam int unsigned FP32_W       = 32;
  localparam int unsigned FP_MULT_LAT  = 3;
  localparam int unsigned RES_W        = FP32_W + 1;
  localparam int unsigned RES_DATA_LSB = 0;
  localparam int unsigned RES_ERR_BIT  = FP32_W;

  typedef logic [FP32_W-1:0] fp32_t;
  typedef logic [RES_W-1:0]  res_entry_t;

  function automatic res_entry_t pack_res(input logic err, input fp32_t data);
    res_entry_t e;
    e = '0;
    e[RES_DATA_LSB +: FP32_W] = data;
    e[RES_ERR_BIT]            = err;
    return e;
  endfunction

endpackage

// File: rtl/fp_mult_result_buffer_if.sv
// Operand-issue / product / result-output handshake bundle of fp_mult_result_buffer.
// master = upstream issuer + consumer side, slave = the result buffer.
interface fp_mult_result_buffer_if;
  import fp_mult_pkg::*;

  logic  in_vld;
  logic  issue_ok;
  fp32_t mult_c;
  logic  mult_err;
  logic  out_vld;
  logic  out_rdy;
  fp32_t out_data;
  logic  out_err;

  modport master (
    output in_vld, mult_c, mult_err, out_rdy,
    input  issue_ok, out_vld, out_data, out_err
  );

  modport slave (
    input  in_vld, mult_c, mult_err, out_rdy,
    output issue_ok, out_vld, out_data, out_err
  );

endinterface

// File: rtl/fp_res_fifo.sv
// Generic synchronous first-word-fall-through FIFO; read data is forced to zero
// while empty. Push on a full FIFO is ignored unless a pop happens the same cycle.
module fp_res_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wptr == rptr);
    // Extra pointer MSB differs only when the write side has lapped the read side.
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    level   = wptr - rptr;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = empty ? '0 : mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fp_mult_result_buffer.sv
// Result buffer behind the non-stallable FP32 multiplier: valid delay line, credit
// return and FWFT result FIFO. Optional error counter under FP_MULT_ERRCNT_EN.
module fp_mult_result_buffer
  import fp_mult_pkg::*;
#(
  parameter int unsigned LAT   = FP_MULT_LAT,
  parameter int unsigned DEPTH = 8
`ifdef FP_MULT_ERRCNT_EN
  , parameter int unsigned ERR_CW = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  fp_mult_result_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
`ifdef FP_MULT_ERRCNT_EN
  , output logic [ERR_CW-1:0]      err_cnt,
  input  logic                     err_cnt_clr
`endif
);

  localparam int unsigned IW = $clog2(LAT + 1);

  logic [LAT-1:0] vld_d;
  logic [IW-1:0]  inflight;
  logic           strobe;
  logic           pop;
  logic           push_acc;
  logic           full;
  logic           empty;
  res_entry_t     head;

  always_comb begin
    strobe   = vld_d[LAT-1];
    pop      = bus.out_vld && bus.out_rdy;
    push_acc = strobe && (!full || pop);
  end

  // Tag delay line: the last stage lines up with the product on mult_c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_d <= '0;
    end else begin
      vld_d[0] <= bus.in_vld;
      for (int unsigned k = 1; k < LAT; k++) vld_d[k] <= vld_d[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({bus.in_vld, strobe})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ovf <= 1'b0;
    else if (strobe && !push_acc) ovf <= 1'b1;
  end

  fp_res_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (strobe),
    .wdata (pack_res(bus.mult_err, bus.mult_c)),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Credits come from registers only, so in_vld never combinationally loops back.
  always_comb begin
    bus.issue_ok = (32'(inflight) + 32'(level)) < DEPTH;
    bus.out_vld  = !empty;
    bus.out_data = head[RES_DATA_LSB +: FP32_W];
    bus.out_err  = head[RES_ERR_BIT];
  end

`ifdef FP_MULT_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_cnt_clr)
      err_cnt <= '0;
    else if (push_acc && bus.mult_err && (err_cnt != '1))
      err_cnt <= err_cnt + ERR_CW'(1);
  end
`endif

  a_inflight_bound: assert property (@(posedge clk) disable iff (rst) 32'(inflight) <= LAT);
  a_level_bound:    assert property (@(posedge clk) disable iff (rst) 32'(level) <= DEPTH);

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Scoreboard bench for fp_mult_result_buffer with a cycle-level queue model and a
// multiplier emulator that replays scheduled products LAT cycles after issue.
module tb_fp_mult_result_buffer;

  localparam int unsigned LAT    = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ERR_CW = 16;
  localparam int unsigned ERRMAX = (1 << ERR_CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mult_result_buffer_if bus ();
  logic [$clog2(DEPTH):0] level;
  logic                   ovf;
`ifdef FP_MULT_ERRCNT_EN
  logic [ERR_CW-1:0]      err_cnt;
  logic                   err_cnt_clr = 1'b0;
`endif

  fp_mult_result_buffer #(
    .LAT   (LAT),
    .DEPTH (DEPTH)
`ifdef FP_MULT_ERRCNT_EN
    , .ERR_CW (ERR_CW)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .level (level),
    .ovf   (ovf)
`ifdef FP_MULT_ERRCNT_EN
    , .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Stimulus-side product for the issue being presented this cycle.
  logic [31:0] in_prod = '0;
  logic        in_err  = 1'b0;

  // Model state: products scheduled for the emulator, products the buffer owes us,
  // and the queue of results the consumer should see in order.
  int unsigned cyc = 0;
  logic [32:0] mult_sched [int unsigned];
  logic [32:0] pending    [int unsigned];
  logic [32:0] exp_q      [$];
  bit          m_ovf  = 1'b0;
  int unsigned m_errs = 0;

  always @(posedge clk) begin
    logic [32:0] e;
    bit          pop_m;
    bit          acc_err;
    int unsigned sz;
    cyc++;
    if (rst) begin
      pending.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_errs = 0;
    end else begin
      sz      = exp_q.size();
      pop_m   = (sz != 0) && bus.out_rdy;
      acc_err = 1'b0;
      if (pending.exists(cyc)) begin
        e = pending[cyc];
        pending.delete(cyc);
        if (sz < DEPTH || pop_m) begin
          exp_q.push_back(e);
          acc_err = e[32];
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop_m) void'(exp_q.pop_front());
`ifdef FP_MULT_ERRCNT_EN
      if (err_cnt_clr) m_errs = 0;
      else if (acc_err && m_errs != ERRMAX) m_errs++;
`else
      if (acc_err) m_errs++;
`endif
      if (bus.in_vld) begin
        mult_sched[cyc + LAT] = {in_err, in_prod};
        pending[cyc + LAT]    = {in_err, in_prod};
      end
    end
  end

  // Multiplier emulator: not reset, so stale products still appear after a reset.
  always @(posedge clk) begin
    #1;
    if (mult_sched.exists(cyc + 1)) begin
      {bus.mult_err, bus.mult_c} = mult_sched[cyc + 1];
      mult_sched.delete(cyc + 1);
    end else begin
      bus.mult_c   = $urandom;
      bus.mult_err = 1'($urandom);
    end
  end

  // Monitor: compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_vld",  64'(bus.out_vld),  64'(0));
      chk("rst_level",    64'(level),        64'(0));
      chk("rst_ovf",      64'(ovf),          64'(0));
      chk("rst_out_data", 64'(bus.out_data), 64'(0));
      chk("rst_out_err",  64'(bus.out_err),  64'(0));
      chk("rst_issue_ok", 64'(bus.issue_ok), 64'(1));
    end else begin
      chk("out_vld", 64'(bus.out_vld), 64'(exp_q.size() != 0));
      if (bus.out_vld && exp_q.size() != 0) begin
        chk("out_data", 64'(bus.out_data), 64'(exp_q[0][31:0]));
        chk("out_err",  64'(bus.out_err),  64'(exp_q[0][32]));
      end
      chk("level",    64'(level),        64'(exp_q.size()));
      chk("ovf",      64'(ovf),          64'(m_ovf));
      chk("issue_ok", 64'(bus.issue_ok), 64'((pending.num() + exp_q.size()) < DEPTH));
`ifdef FP_MULT_ERRCNT_EN
      chk("err_cnt",  64'(err_cnt),      64'(m_errs));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] credit_vals [$];
    int unsigned lat;
    int unsigned issues;

    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    bus.mult_c = '0;
    bus.mult_err = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Random traffic, mostly honouring credits, occasionally not.
    repeat (400) begin
      bus.in_vld  = ($urandom_range(0, 15) == 0) ? 1'b1 : (bus.issue_ok && ($urandom_range(0, 2) != 0));
      in_prod     = $urandom;
      in_err      = ($urandom_range(0, 3) == 0);
      bus.out_rdy = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Reset in the middle of a stream; stale products must never surface.
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1;
    in_prod     = 32'h1234_5678;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (LAT + 4) tick();
    chk("post_rst_level", 64'(level), 64'(0));
    chk("post_rst_ovf",   64'(ovf),   64'(0));

    // Single op: 1.5 * 1.5 = 2.25.
    in_prod    = 32'h4010_0000;
    in_err     = 1'b0;
    bus.in_vld = 1'b1;
    tick();
    bus.in_vld = 1'b0;
    lat = 1;
    while (!bus.out_vld && lat < 20) begin
      tick();
      lat++;
    end
    chk("single_latency", 64'(lat), 64'(LAT + 1));
    chk("single_data",    64'(bus.out_data), 64'(32'h4010_0000));
    chk("single_err",     64'(bus.out_err),  64'(0));
    repeat (2) tick();

    // Back-to-back with a stalled consumer: 2.25 then 3.0625.
    bus.out_rdy = 1'b0;
    in_prod     = 32'h4010_0000;
    bus.in_vld  = 1'b1;
    tick();
    in_prod     = 32'h4044_0000;
    tick();
    bus.in_vld  = 1'b0;
    repeat (LAT + 4) tick();
    chk("stall_head",  64'(bus.out_data), 64'(32'h4010_0000));
    chk("stall_level", 64'(level),        64'(2));
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    chk("second_head", 64'(bus.out_data), 64'(32'h4044_0000));
    bus.out_rdy = 1'b1;
    repeat (3) tick();

    // Credit: issue whenever allowed with nothing draining.
    bus.out_rdy = 1'b0;
    issues = 0;
    repeat (DEPTH * 3 + LAT) begin
      bus.in_vld = bus.issue_ok;
      in_prod    = $urandom;
      in_err     = 1'b0;
      if (bus.in_vld) begin
        issues++;
        credit_vals.push_back(in_prod);
      end
      tick();
    end
    bus.in_vld = 1'b0;
    repeat (LAT + 2) tick();
    chk("credit_issues",   64'(issues),       64'(DEPTH));
    chk("credit_level",    64'(level),        64'(DEPTH));
    chk("credit_issue_ok", 64'(bus.issue_ok), 64'(0));
    chk("credit_ovf",      64'(ovf),          64'(0));

    // Overflow: push past a full FIFO.
    in_prod    = 32'hDEAD_BEEF;
    bus.in_vld = 1'b1;
    tick();
    bus.in_vld = 1'b0;
    repeat (LAT + 2) tick();
    chk("ovf_set",   64'(ovf),          64'(1));
    chk("ovf_level", 64'(level),        64'(DEPTH));
    chk("ovf_head",  64'(bus.out_data), 64'(credit_vals[0]));
    bus.out_rdy = 1'b1;
    repeat (DEPTH + 2) tick();
    chk("drain_level", 64'(level), 64'(0));

`ifdef FP_MULT_ERRCNT_EN
    // Error counting, clear, and saturation.
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    bus.out_rdy = 1'b0;
    in_err      = 1'b1;
    repeat (3) begin
      in_prod    = $urandom;
      bus.in_vld = 1'b1;
      tick();
    end
    bus.in_vld = 1'b0;
    repeat (LAT + 2) tick();
    chk("err_cnt_3", 64'(err_cnt), 64'(3));
    bus.out_rdy = 1'b1;
    repeat (5) tick();
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    chk("err_cnt_clr", 64'(err_cnt), 64'(0));
    bus.in_vld = 1'b1;
    repeat (ERRMAX + 8) begin
      in_prod = $urandom;
      tick();
    end
    bus.in_vld = 1'b0;
    in_err     = 1'b0;
    repeat (LAT + 3) tick();
    chk("err_cnt_sat", 64'(err_cnt), 64'(ERRMAX));
`endif

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
